// File: rtl/ripple_pkg.sv
// ripple_pkg: shared types and defaults for the ripple counter checker.
//   state_t            - checker FSM state encoding
//   RIPPLE_LOCK_LEN_DEF - default number of consecutive good increments to lock
//   RIPPLE_ERR_W_DEF    - default width of the fault and wrap counters
//   ripple_next()       - expected successor of a 4-bit ripple count
package ripple_pkg;

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam int RIPPLE_LOCK_LEN_DEF = 3;
  localparam int RIPPLE_ERR_W_DEF    = 8;

  // A 4-bit ripple counter rolls 15 -> 0, so the successor is mod 16.
  function automatic logic [3:0] ripple_next(input logic [3:0] v);
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clock - rising-edge clock
//   reset - asynchronous active-low reset, clears count
//   inc   - increment (sticks at all-ones)
//   clr   - clear; when coincident with inc the increment wins and the
//           result is 1 (clear first, then count the new event)
//   count - current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (inc) begin
      if (clr)
        count <= WIDTH'(1);
      else if (!(&count))
        count <= count + WIDTH'(1);
    end else if (clr)
      count <= '0;
  end

endmodule

// File: rtl/ripple_count_checker.sv
// ripple_count_checker: watches a free-running 4-bit ripple counter and
// checks that every sample is the previous sample plus one (mod 16).
// The upstream counter moves on the falling edge, so q is sampled on the
// rising edge with a half period of settling.
//   clock      - rising-edge sample clock
//   reset      - asynchronous active-low reset
//   q          - count under check
//   enable     - checking enabled; low forces UNSYNC, counters hold
//   clear_err  - synchronous clear of error / err_count (a fault wins)
//   locked     - FSM is in LOCKED
//   error      - sticky fault flag
//   err_count  - saturating fault count
//   wrap_count - 15->0 transitions seen while locked, modulo 2^ERR_W
//   last_q     - q from the previous enabled cycle
module ripple_count_checker
  import ripple_pkg::*;
#(
  parameter int LOCK_LEN = RIPPLE_LOCK_LEN_DEF,
  parameter int ERR_W    = RIPPLE_ERR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       q,
  input  logic             enable,
  input  logic             clear_err,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [3:0]       last_q
);

  state_t     state, state_nxt;
  logic [3:0] good_run, good_run_nxt, good_run_inc;
  logic       good, fault, wrap;

  // A stall (q == last_q) fails this test too, so it is a mismatch.
  assign good         = (q == ripple_next(last_q));
  assign good_run_inc = good_run + 4'd1;
  // Faults are only recorded from LOCKED; mismatches in ACQUIRE just
  // restart the run.
  assign fault        = enable && (state == ST_LOCKED) && !good;
  assign wrap         = enable && (state == ST_LOCKED) && good && (last_q == 4'hF);
  assign locked       = (state == ST_LOCKED);

  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    if (!enable) begin
      state_nxt    = ST_UNSYNC;
      good_run_nxt = 4'd0;
    end else begin
      case (state)
        ST_UNSYNC: begin
          state_nxt    = ST_ACQUIRE;
          good_run_nxt = 4'd0;
        end
        ST_ACQUIRE: begin
          if (good) begin
            good_run_nxt = good_run_inc;
            if (good_run_inc == 4'(LOCK_LEN))
              state_nxt = ST_LOCKED;
          end else
            good_run_nxt = 4'd0;
        end
        ST_LOCKED: begin
          if (!good) begin
            state_nxt    = ST_FAULT;
            good_run_nxt = 4'd0;
          end
        end
        ST_FAULT: begin
          state_nxt    = ST_ACQUIRE;
          good_run_nxt = 4'd0;
        end
        default: begin
          state_nxt    = ST_UNSYNC;
          good_run_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_UNSYNC;
      good_run <= 4'd0;
      last_q   <= 4'd0;
    end else begin
      state    <= state_nxt;
      good_run <= good_run_nxt;
      if (enable)
        last_q <= q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      error <= 1'b0;
    else if (fault)
      error <= 1'b1;
    else if (clear_err)
      error <= 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wrap_count <= '0;
    else if (wrap)
      wrap_count <= wrap_count + ERR_W'(1);
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (fault),
    .clr   (clear_err),
    .count (err_count)
  );

endmodule

// File: doc/ripple_count_checker.md
RIPPLE_COUNT_CHECKER -- requirements
Module: ripple_count_checker

Interface
REQ-001 The block SHALL have parameter LOCK_LEN, default 3, giving the number of consecutive good increments needed to lock (range 1..15).
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of err_count and wrap_count.
REQ-003 The block SHALL have port clock  input  1  single clock; sampling on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port q  input  4  count value under check, driven by the upstream 4-bit ripple counter.
REQ-006 The block SHALL have port enable  input  1  checking enabled.
REQ-007 The block SHALL have port clear_err  input  1  synchronous clear of the sticky error flag and err_count.
REQ-008 The block SHALL have port locked  output  1  checker is in LOCKED.
REQ-009 The block SHALL have port error  output  1  sticky sequence-fault flag.
REQ-010 The block SHALL have port err_count  output  ERR_W  saturating count of faults.
REQ-011 The block SHALL have port wrap_count  output  ERR_W  count of 15->0 transitions seen while locked, modulo 2^ERR_W.
REQ-012 The block SHALL have port last_q  output  4  q sampled on the previous enabled cycle.

Function
REQ-013 The block SHALL sample q on every rising clock edge (the upstream counter changes on the falling edge, leaving a half period to settle).
REQ-014 "Good" SHALL mean q == (last_q + 1) mod 16; q == last_q (stall) or any other value SHALL count as a mismatch.
REQ-015 The FSM SHALL have the states UNSYNC, ACQUIRE, LOCKED and FAULT.
REQ-016 In UNSYNC with enable=1, the block SHALL load last_q<=q, clear good_run and go to ACQUIRE.
REQ-017 In ACQUIRE, a good sample SHALL increment good_run; when good_run reaches LOCK_LEN, the next state SHALL be LOCKED.
REQ-018 In ACQUIRE, a mismatch SHALL clear good_run and stay in ACQUIRE, and no error SHALL be recorded.
REQ-019 In LOCKED, a mismatch SHALL go to FAULT, set error and increment err_count (saturating at all-ones), all registered one cycle after the offending sample.
REQ-020 In LOCKED, a good sample with last_q=15 and q=0 SHALL increment wrap_count, wrapping modulo 2^ERR_W.
REQ-021 FAULT SHALL last exactly one cycle, then go to ACQUIRE with good_run=0.
REQ-022 locked SHALL be 1 only in LOCKED.
REQ-023 last_q SHALL update to q on every enabled cycle in every state.
REQ-024 enable=0 in any state SHALL force UNSYNC on the next edge; last_q, err_count, wrap_count and error SHALL hold.
REQ-025 clear_err=1 SHALL clear error and err_count on the next edge; a fault in the same cycle SHALL win (error=1, err_count=1).
REQ-026 err_count at all-ones plus a further fault SHALL remain all-ones with error=1.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for a clock edge, force state=UNSYNC, good_run=0, last_q=0, locked=0, error=0, err_count=0 and wrap_count=0.
REQ-028 reset asserted mid-operation SHALL discard any partial lock progress; after release, the block SHALL re-acquire from UNSYNC.

Structure
REQ-029 The state encoding typedef and the default LOCK_LEN and ERR_W constants SHALL reside in the shared package ripple_pkg.
REQ-030 The saturating err_count SHALL be a sub-module sat_counter (parameter width; ports inc and clr, clr lower priority than inc).
REQ-031 The implementation SHALL be 120-400 lines of RTL, fully synchronous apart from the asynchronous reset.

Verification
REQ-032 Release reset with enable=1 and q counting 0,1,2,3,4 -> locked=1 on the edge after q=3 is sampled; error=0.
REQ-033 While locked, q sequence 14,15,0,1 -> wrap_count increments by 1 at 15->0; locked stays 1.
REQ-034 While locked, q sequence 5,6,9 -> error=1 and err_count=1 one cycle after the 9; FAULT for one cycle; then ACQUIRE with locked=0; relock after 3 good samples.
REQ-035 While locked, a stall 7,7 -> treated as a fault, error=1.
REQ-036 With error=1, pulse clear_err coincident with a new fault -> error=1, err_count=1; a later clear_err alone -> error=0, err_count=0.
REQ-037 Assert reset mid-count with err_count=5 -> all outputs 0 immediately, without a clock edge; after release the block re-locks from UNSYNC.
